// File: rtl/cdb_writeback_arbiter.sv
// Writeback arbiter for the single-lane common data bus.
// Each functional unit owns a small FIFO. Every cycle one non-empty head is
// granted: a starving head wins first, otherwise the oldest ROB index wins.
// The winner is registered onto the CDB broadcast.
module cdb_writeback_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 32,
  parameter int ROB_IDX_W    = 5,
  parameter int BUF_DEPTH    = 2,
  parameter int STARVE_LIMIT = 8,
  localparam int SRC_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic [ROB_IDX_W-1:0]              rob_head,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]    req_data,
  input  logic [NUM_REQ-1:0][4:0]           req_rd_addr,
  input  logic [NUM_REQ-1:0][ROB_IDX_W-1:0] req_rob_idx,
  output logic                              cdb_valid,
  output logic [DATA_W-1:0]                 cdb_data,
  output logic [4:0]                        cdb_rd_addr,
  output logic [ROB_IDX_W-1:0]              cdb_rob_idx,
  output logic [SRC_W-1:0]                  cdb_src
);

  localparam int PTR_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W  = $clog2(BUF_DEPTH + 1);
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

  // Per-unit FIFO storage, indexed [unit][slot]
  logic [DATA_W-1:0]    fifo_data [NUM_REQ][BUF_DEPTH];
  logic [4:0]           fifo_rd   [NUM_REQ][BUF_DEPTH];
  logic [ROB_IDX_W-1:0] fifo_rob  [NUM_REQ][BUF_DEPTH];

  logic [PTR_W-1:0]     wr_ptr   [NUM_REQ];
  logic [PTR_W-1:0]     rd_ptr   [NUM_REQ];
  logic [CNT_W-1:0]     count    [NUM_REQ];
  logic [WAIT_W-1:0]    wait_cnt [NUM_REQ];

  logic [NUM_REQ-1:0]   push;
  logic [NUM_REQ-1:0]   pop;
  logic [NUM_REQ-1:0]   not_empty;
  logic [NUM_REQ-1:0]   starving;
  logic [ROB_IDX_W-1:0] head_age [NUM_REQ];

  logic                 grant_any;
  logic [SRC_W-1:0]     grant_idx;
  logic [ROB_IDX_W-1:0] best_age;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(BUF_DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // Ready depends only on the stored count, so a same-cycle pop never makes room
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = rst_n && !flush && (count[i] < CNT_W'(BUF_DEPTH));
    end
  end

  assign push = req_valid & req_ready;

  // Head status: occupancy, starvation and age relative to the ROB head (wrapping)
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      not_empty[i] = (count[i] != '0);
      starving[i]  = (count[i] != '0) && (wait_cnt[i] == WAIT_W'(STARVE_LIMIT));
      head_age[i]  = fifo_rob[i][rd_ptr[i]] - rob_head;
    end
  end

  // Pick the lowest starving unit, else the oldest head with ties to the lowest index
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    best_age  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (starving[i] && !grant_any) begin
        grant_any = 1'b1;
        grant_idx = SRC_W'(i);
      end
    end
    if (!grant_any) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (not_empty[i] && (!grant_any || (head_age[i] < best_age))) begin
          grant_any = 1'b1;
          grant_idx = SRC_W'(i);
          best_age  = head_age[i];
        end
      end
    end
  end

  // A flush cycle never pops, so nothing is broadcast or lost to the grant
  always_comb begin
    pop = '0;
    if (grant_any && !flush) begin
      pop[grant_idx] = 1'b1;
    end
  end

  // FIFO payload writes; no reset needed since occupancy is tracked separately
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (push[i]) begin
        fifo_data[i][wr_ptr[i]] <= req_data[i];
        fifo_rd[i][wr_ptr[i]]   <= req_rd_addr[i];
        fifo_rob[i][wr_ptr[i]]  <= req_rob_idx[i];
      end
    end
  end

  // FIFO pointers, counts, wait counters and the registered CDB broadcast
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        wr_ptr[i]   <= '0;
        rd_ptr[i]   <= '0;
        count[i]    <= '0;
        wait_cnt[i] <= '0;
      end
      cdb_valid   <= 1'b0;
      cdb_data    <= '0;
      cdb_rd_addr <= '0;
      cdb_rob_idx <= '0;
      cdb_src     <= '0;
    end else if (flush) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        wr_ptr[i]   <= '0;
        rd_ptr[i]   <= '0;
        count[i]    <= '0;
        wait_cnt[i] <= '0;
      end
      cdb_valid <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (push[i]) begin
          wr_ptr[i] <= ptr_next(wr_ptr[i]);
        end
        if (pop[i]) begin
          rd_ptr[i] <= ptr_next(rd_ptr[i]);
        end
        count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
        if (!not_empty[i] || pop[i]) begin
          wait_cnt[i] <= '0;
        end else if (wait_cnt[i] != WAIT_W'(STARVE_LIMIT)) begin
          wait_cnt[i] <= wait_cnt[i] + WAIT_W'(1);
        end
      end
      if (grant_any) begin
        cdb_valid   <= 1'b1;
        cdb_data    <= fifo_data[grant_idx][rd_ptr[grant_idx]];
        cdb_rd_addr <= fifo_rd[grant_idx][rd_ptr[grant_idx]];
        cdb_rob_idx <= fifo_rob[grant_idx][rd_ptr[grant_idx]];
        cdb_src     <= grant_idx;
      end else begin
        cdb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// Bench for cdb_writeback_arbiter: directed scenarios with literal expectations
// plus a queue-based model compared against the DUT on every cycle.
module tb_cdb_writeback_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int DATA_W       = 32;
  localparam int ROB_IDX_W    = 5;
  localparam int BUF_DEPTH    = 2;
  localparam int STARVE_LIMIT = 8;

  logic                              clk = 1'b0;
  logic                              rst_n;
  logic                              flush;
  logic [ROB_IDX_W-1:0]              rob_head;
  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ-1:0]                req_ready;
  logic [NUM_REQ-1:0][DATA_W-1:0]    req_data;
  logic [NUM_REQ-1:0][4:0]           req_rd_addr;
  logic [NUM_REQ-1:0][ROB_IDX_W-1:0] req_rob_idx;
  logic                              cdb_valid;
  logic [DATA_W-1:0]                 cdb_data;
  logic [4:0]                        cdb_rd_addr;
  logic [ROB_IDX_W-1:0]              cdb_rob_idx;
  logic [1:0]                        cdb_src;

  int total = 0;
  int bad   = 0;

  cdb_writeback_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ROB_IDX_W(ROB_IDX_W),
    .BUF_DEPTH(BUF_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .rob_head(rob_head),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_rd_addr(req_rd_addr), .req_rob_idx(req_rob_idx),
    .cdb_valid(cdb_valid), .cdb_data(cdb_data), .cdb_rd_addr(cdb_rd_addr),
    .cdb_rob_idx(cdb_rob_idx), .cdb_src(cdb_src)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0]    data;
    logic [4:0]           rd;
    logic [ROB_IDX_W-1:0] rob;
  } entry_t;

  // Model state: one queue per unit, a wait count per unit, expected CDB
  entry_t             mq [NUM_REQ][$];
  int                 mwait [NUM_REQ];
  logic               m_valid;
  logic [DATA_W-1:0]  m_data;
  logic [4:0]         m_rd;
  logic [4:0]         m_rob;
  logic [1:0]         m_src;
  int                 m_win;
  int                 m_best;
  int                 m_age;
  int                 m_size [NUM_REQ];
  entry_t             m_ent;
  logic [NUM_REQ-1:0] exp_ready;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update at each edge using the inputs held during the cycle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        mq[i].delete();
        mwait[i] = 0;
      end
      m_valid = 1'b0;
      m_data  = '0;
      m_rd    = '0;
      m_rob   = '0;
      m_src   = '0;
    end else if (flush) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        mq[i].delete();
        mwait[i] = 0;
      end
      m_valid = 1'b0;
    end else begin
      m_win = -1;
      for (int i = 0; i < NUM_REQ; i++) begin
        m_size[i] = mq[i].size();
        if (m_win < 0 && m_size[i] > 0 && mwait[i] == STARVE_LIMIT) m_win = i;
      end
      if (m_win < 0) begin
        m_best = 1 << ROB_IDX_W;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (m_size[i] > 0) begin
            m_age = (int'(mq[i][0].rob) - int'(rob_head)) & ((1 << ROB_IDX_W) - 1);
            if (m_age < m_best) begin
              m_best = m_age;
              m_win  = i;
            end
          end
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (m_size[i] == 0 || i == m_win) mwait[i] = 0;
        else if (mwait[i] < STARVE_LIMIT) mwait[i] = mwait[i] + 1;
      end
      if (m_win >= 0) begin
        m_ent   = mq[m_win].pop_front();
        m_valid = 1'b1;
        m_data  = m_ent.data;
        m_rd    = m_ent.rd;
        m_rob   = m_ent.rob;
        m_src   = 2'(m_win);
      end else begin
        m_valid = 1'b0;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && m_size[i] < BUF_DEPTH) begin
          mq[i].push_back({req_data[i], req_rd_addr[i], req_rob_idx[i]});
        end
      end
    end
  end

  // Compare DUT against the model mid-cycle whenever out of reset
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) exp_ready[i] = !flush && (mq[i].size() < BUF_DEPTH);
      checkOutput("model cdb_valid", 64'(cdb_valid), 64'(m_valid));
      checkOutput("model cdb_data", 64'(cdb_data), 64'(m_data));
      checkOutput("model cdb_rd_addr", 64'(cdb_rd_addr), 64'(m_rd));
      checkOutput("model cdb_rob_idx", 64'(cdb_rob_idx), 64'(m_rob));
      checkOutput("model cdb_src", 64'(cdb_src), 64'(m_src));
      checkOutput("model req_ready", 64'(req_ready), 64'(exp_ready));
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #2;
    req_valid = '0;
    flush     = 1'b0;
  endtask

  task automatic midCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) nextCycle();
  endtask

  task automatic applyStimulus(input int unit, input logic [31:0] data,
                               input logic [4:0] rd, input logic [4:0] rob);
    req_valid[unit]   = 1'b1;
    req_data[unit]    = data;
    req_rd_addr[unit] = rd;
    req_rob_idx[unit] = rob;
  endtask

  // Directed scenarios
  initial begin
    rst_n       = 1'b1;
    flush       = 1'b0;
    rob_head    = '0;
    req_valid   = '0;
    req_data    = '0;
    req_rd_addr = '0;
    req_rob_idx = '0;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset cdb_valid", 64'(cdb_valid), 64'd0);
    checkOutput("reset cdb_data", 64'(cdb_data), 64'd0);
    checkOutput("reset req_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;

    $display("[TB] single ALU result latency");
    applyStimulus(0, 32'hDEADBEEF, 5'd5, 5'd3);
    nextCycle();
    midCycle();
    checkOutput("t1 cycle1 valid", 64'(cdb_valid), 64'd0);
    nextCycle();
    midCycle();
    checkOutput("t1 cycle2 valid", 64'(cdb_valid), 64'd1);
    checkOutput("t1 cycle2 data", 64'(cdb_data), 64'hDEADBEEF);
    checkOutput("t1 cycle2 rd", 64'(cdb_rd_addr), 64'd5);
    checkOutput("t1 cycle2 rob", 64'(cdb_rob_idx), 64'd3);
    checkOutput("t1 cycle2 src", 64'(cdb_src), 64'd0);
    nextCycle();
    midCycle();
    checkOutput("t1 cycle3 valid", 64'(cdb_valid), 64'd0);
    idle(3);

    $display("[TB] wrapping age order");
    rob_head = 5'd30;
    applyStimulus(1, 32'h11110031, 5'd7, 5'd31);
    applyStimulus(3, 32'h33330001, 5'd8, 5'd1);
    nextCycle();
    nextCycle();
    midCycle();
    checkOutput("t2 first src", 64'(cdb_src), 64'd1);
    checkOutput("t2 first rob", 64'(cdb_rob_idx), 64'd31);
    nextCycle();
    midCycle();
    checkOutput("t2 second src", 64'(cdb_src), 64'd3);
    checkOutput("t2 second rob", 64'(cdb_rob_idx), 64'd1);
    idle(3);

    $display("[TB] equal age tie break");
    rob_head = 5'd0;
    applyStimulus(2, 32'h22220007, 5'd2, 5'd7);
    applyStimulus(0, 32'h00000007, 5'd1, 5'd7);
    nextCycle();
    nextCycle();
    midCycle();
    checkOutput("t3 first src", 64'(cdb_src), 64'd0);
    nextCycle();
    midCycle();
    checkOutput("t3 second src", 64'(cdb_src), 64'd2);
    idle(3);

    $display("[TB] starvation override");
    for (int k = 0; k < 14; k++) begin
      if (k < 12) applyStimulus(0, 32'h100 + k, 5'd1, 5'(k + 1));
      if (k == 0) applyStimulus(3, 32'hCAFE0010, 5'd9, 5'd10);
      midCycle();
      if (k == 9) begin
        checkOutput("t4 cycle9 src", 64'(cdb_src), 64'd0);
        checkOutput("t4 cycle9 rob", 64'(cdb_rob_idx), 64'd8);
      end
      if (k == 10) begin
        checkOutput("t4 starve valid", 64'(cdb_valid), 64'd1);
        checkOutput("t4 starve src", 64'(cdb_src), 64'd3);
        checkOutput("t4 starve rob", 64'(cdb_rob_idx), 64'd10);
        checkOutput("t4 starve data", 64'(cdb_data), 64'hCAFE0010);
      end
      if (k == 11) begin
        checkOutput("t4 after src", 64'(cdb_src), 64'd0);
        checkOutput("t4 after rob", 64'(cdb_rob_idx), 64'd9);
      end
      nextCycle();
    end
    idle(4);

    $display("[TB] MUL FIFO full and ready timing");
    for (int k = 0; k < 8; k++) begin
      if (k < 4) applyStimulus(0, 32'h200 + k, 5'd3, 5'(k + 1));
      if (k < 3) applyStimulus(1, 32'h300 + k, 5'd4, 5'(k + 20));
      midCycle();
      if (k == 2) checkOutput("t5 full ready", 64'(req_ready[1]), 64'd0);
      if (k == 5) checkOutput("t5 pop-cycle ready", 64'(req_ready[1]), 64'd0);
      if (k == 6) begin
        checkOutput("t5 after-pop ready", 64'(req_ready[1]), 64'd1);
        checkOutput("t5 mul src", 64'(cdb_src), 64'd1);
        checkOutput("t5 mul rob", 64'(cdb_rob_idx), 64'd20);
      end
      nextCycle();
    end
    idle(4);

    $display("[TB] flush");
    for (int k = 0; k < 7; k++) begin
      if (k == 0) begin
        applyStimulus(0, 32'h401, 5'd1, 5'd1);
        applyStimulus(1, 32'h402, 5'd2, 5'd2);
        applyStimulus(2, 32'h403, 5'd3, 5'd3);
        applyStimulus(3, 32'h404, 5'd4, 5'd4);
      end
      if (k == 1) begin
        applyStimulus(1, 32'h405, 5'd5, 5'd5);
        applyStimulus(2, 32'h406, 5'd6, 5'd6);
      end
      if (k == 2) begin
        flush = 1'b1;
        applyStimulus(0, 32'hBAD00009, 5'd9, 5'd9);
      end
      midCycle();
      if (k == 2) begin
        checkOutput("t6 flush ready", 64'(req_ready), 64'h0);
        checkOutput("t6 pre-flush valid", 64'(cdb_valid), 64'd1);
        checkOutput("t6 pre-flush rob", 64'(cdb_rob_idx), 64'd1);
      end
      if (k == 3) checkOutput("t6 post-flush ready", 64'(req_ready), 64'hF);
      if (k >= 3) checkOutput("t6 post-flush valid", 64'(cdb_valid), 64'd0);
      nextCycle();
    end

    $display("[TB] async reset mid-burst");
    applyStimulus(0, 32'h501, 5'd1, 5'd1);
    applyStimulus(1, 32'h502, 5'd2, 5'd2);
    nextCycle();
    applyStimulus(2, 32'h503, 5'd3, 5'd3);
    nextCycle();
    midCycle();
    checkOutput("t7 burst valid", 64'(cdb_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("t7 reset valid", 64'(cdb_valid), 64'd0);
    checkOutput("t7 reset data", 64'(cdb_data), 64'd0);
    checkOutput("t7 reset rob", 64'(cdb_rob_idx), 64'd0);
    checkOutput("t7 reset rd", 64'(cdb_rd_addr), 64'd0);
    checkOutput("t7 reset src", 64'(cdb_src), 64'd0);
    checkOutput("t7 reset ready", 64'(req_ready), 64'd0);
    nextCycle();
    nextCycle();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      midCycle();
      checkOutput("t7 lost entries", 64'(cdb_valid), 64'd0);
      nextCycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
